// File: rtl/seg7_scan_counter.sv
// Multi-digit up/down hex/BCD counter with debounced push-buttons, driving a
// time-multiplexed common-cathode seven-segment display.
module seg7_scan_counter #(
  parameter int NUM_DIGITS = 4,
  parameter int DIV_W      = 26,
  parameter int TAP0       = 15,
  parameter int TAP1       = 19,
  parameter int TAP2       = 25,
  parameter int DEB_CYCLES = 65536
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    inc,
  input  logic                    dec,
  input  logic                    clr,
  input  logic                    ss,
  input  logic                    mode_bcd,
  output logic [NUM_DIGITS-1:0]   grounds,
  output logic [6:0]              display,
  output logic [4*NUM_DIGITS-1:0] value,
  output logic                    wrap
);

  localparam int VW    = 4 * NUM_DIGITS;
  localparam int CNT_W = $clog2(DEB_CYCLES + 1);
  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'h0: seg7 = 7'b1111110;  4'h1: seg7 = 7'b0110000;
      4'h2: seg7 = 7'b1101101;  4'h3: seg7 = 7'b1111001;
      4'h4: seg7 = 7'b0110011;  4'h5: seg7 = 7'b1011011;
      4'h6: seg7 = 7'b1011111;  4'h7: seg7 = 7'b1110000;
      4'h8: seg7 = 7'b1111111;  4'h9: seg7 = 7'b1111011;
      4'hA: seg7 = 7'b1110111;  4'hB: seg7 = 7'b0011111;
      4'hC: seg7 = 7'b1001110;  4'hD: seg7 = 7'b0111101;
      4'hE: seg7 = 7'b1001111;  default: seg7 = 7'b1000111;
    endcase
  endfunction

  function automatic logic tap_bit(input logic [1:0] sel, input logic [DIV_W-1:0] d);
    case (sel)
      2'd0:    tap_bit = d[TAP0];
      2'd1:    tap_bit = d[TAP1];
      default: tap_bit = d[TAP2];
    endcase
  endfunction

  // Buttons, bit order {ss, clr, dec, inc}: sync -> debounce -> press event.
  logic [3:0]       btn_raw;
  logic [3:0]       sync_p0, sync_p1, deb_p2, deb_p3, arm, evt_p4;
  logic [1:0]       fill;
  logic [CNT_W-1:0] deb_cnt [4];

  assign btn_raw = {ss, clr, dec, inc};

  // A button must be seen released after reset (arm) before a press counts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0 <= '1;
      sync_p1 <= '1;
      deb_p2  <= '1;
      deb_p3  <= '1;
      arm     <= '0;
      evt_p4  <= '0;
      fill    <= '0;
      for (int b = 0; b < 4; b++) deb_cnt[b] <= '0;
    end else begin
      sync_p0 <= btn_raw;
      sync_p1 <= sync_p0;
      deb_p3  <= deb_p2;
      fill    <= {fill[0], 1'b1};
      arm     <= arm | ({4{fill[1]}} & sync_p1);
      evt_p4  <= deb_p3 & ~deb_p2 & arm;
      for (int b = 0; b < 4; b++) begin
        if (sync_p1[b] != deb_p2[b]) begin
          if (deb_cnt[b] == DEB_LAST) begin
            deb_p2[b]  <= sync_p1[b];
            deb_cnt[b] <= '0;
          end else begin
            deb_cnt[b] <= deb_cnt[b] + 1'b1;
          end
        end else begin
          deb_cnt[b] <= '0;
        end
      end
    end
  end

  logic inc_e, dec_e, clr_e, ss_e;
  assign inc_e = evt_p4[0];
  assign dec_e = evt_p4[1];
  assign clr_e = evt_p4[2];
  assign ss_e  = evt_p4[3];

  // Mode input: sync, then edge detect against a delayed copy.
  logic mode_p0, mode_p1, mode_p2, mode_chg;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_p0 <= 1'b0;
      mode_p1 <= 1'b0;
      mode_p2 <= 1'b0;
    end else begin
      mode_p0 <= mode_bcd;
      mode_p1 <= mode_p0;
      mode_p2 <= mode_p1;
    end
  end
  assign mode_chg = mode_p1 ^ mode_p2;

  logic [VW-1:0] cnt, inc_v, dec_v;
  logic [3:0]    dmax, dig;
  logic          carry, borrow, all_max, all_zero;

  always_comb begin
    dmax     = mode_p1 ? 4'd9 : 4'd15;
    inc_v    = cnt;
    dec_v    = cnt;
    dig      = '0;
    carry    = 1'b1;
    borrow   = 1'b1;
    all_max  = 1'b1;
    all_zero = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      dig      = cnt[4*i +: 4];
      all_max  = all_max & (dig == dmax);
      all_zero = all_zero & (dig == 4'd0);
      if (carry) begin
        if (dig == dmax) inc_v[4*i +: 4] = 4'd0;
        else begin
          inc_v[4*i +: 4] = dig + 4'd1;
          carry = 1'b0;
        end
      end
      if (borrow) begin
        if (dig == 4'd0) dec_v[4*i +: 4] = dmax;
        else begin
          dec_v[4*i +: 4] = dig - 4'd1;
          borrow = 1'b0;
        end
      end
    end
  end

  // Counter update, one cycle after the press events.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      wrap <= 1'b0;
    end else begin
      wrap <= 1'b0;
      if (clr_e || mode_chg) begin
        cnt <= '0;
      end else if (inc_e && !dec_e) begin
        cnt  <= inc_v;
        wrap <= all_max;
      end else if (dec_e && !inc_e) begin
        cnt  <= dec_v;
        wrap <= all_zero;
      end
    end
  end
  assign value = cnt;

  logic [DIV_W-1:0] div;
  logic [1:0]       rate_sel, rate_nxt;
  logic             tap_q, tick;
  logic [IDX_W-1:0] idx, idx_nxt;

  assign rate_nxt = (rate_sel == 2'd2) ? 2'd0 : rate_sel + 2'd1;
  assign tick     = tap_bit(rate_sel, div) & ~tap_q;
  assign idx_nxt  = (idx == IDX_LAST) ? '0 : idx + 1'b1;

  // Scan stage; on a rate switch the history bit is taken from the new tap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div      <= '0;
      rate_sel <= 2'd0;
      tap_q    <= 1'b0;
      idx      <= '0;
      grounds  <= ~NUM_DIGITS'(1);
    end else begin
      div <= div + 1'b1;
      if (ss_e) begin
        rate_sel <= rate_nxt;
        tap_q    <= tap_bit(rate_nxt, div);
      end else begin
        tap_q    <= tap_bit(rate_sel, div);
      end
      if (tick) begin
        idx     <= idx_nxt;
        grounds <= ~(NUM_DIGITS'(1) << idx_nxt);
      end
    end
  end

  assign display = seg7(cnt[{idx, 2'b00} +: 4]);

endmodule

// File: tb/tb_seg7_scan_counter.sv
// Bench for seg7_scan_counter: arithmetic value model, prescaler-phase scan
// model, randomized button sequences.
module tb_seg7_scan_counter;
  localparam int DEB = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        inc = 1'b1, dec = 1'b1, clr = 1'b1, ss = 1'b1, mode_bcd = 1'b0;
  logic [3:0]  grounds;
  logic [6:0]  display;
  logic [15:0] value;
  logic        wrap;

  int n_checks = 0;
  int n_fail   = 0;
  int wrap_hi  = 0;
  int wrap_exp = 0;
  int mv       = 0;
  bit mb       = 1'b0;

  seg7_scan_counter #(
    .NUM_DIGITS(4), .DIV_W(8), .TAP0(1), .TAP1(2), .TAP2(3), .DEB_CYCLES(DEB)
  ) dut (
    .clk(clk), .rst_n(rst_n), .inc(inc), .dec(dec), .clr(clr), .ss(ss),
    .mode_bcd(mode_bcd), .grounds(grounds), .display(display),
    .value(value), .wrap(wrap)
  );

  always #5 clk = ~clk;
  always @(negedge clk) if (wrap === 1'b1) wrap_hi++;

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    case (d)
      4'h0: return 7'b1111110;  4'h1: return 7'b0110000;
      4'h2: return 7'b1101101;  4'h3: return 7'b1111001;
      4'h4: return 7'b0110011;  4'h5: return 7'b1011011;
      4'h6: return 7'b1011111;  4'h7: return 7'b1110000;
      4'h8: return 7'b1111111;  4'h9: return 7'b1111011;
      4'hA: return 7'b1110111;  4'hB: return 7'b0011111;
      4'hC: return 7'b1001110;  4'hD: return 7'b0111101;
      4'hE: return 7'b1001111;  default: return 7'b1000111;
    endcase
  endfunction

  function automatic logic [15:0] exp_value();
    if (mb) return {4'(mv / 1000 % 10), 4'(mv / 100 % 10), 4'(mv / 10 % 10), 4'(mv % 10)};
    return 16'(mv);
  endfunction

  // op: 0 inc, 1 dec, 2 clr, 3 inc+dec together, 4 clr+inc together
  function automatic void model_op(input int op);
    int m = mb ? 10000 : 65536;
    case (op)
      0: begin if (mv == m - 1) wrap_exp++; mv = (mv + 1) % m; end
      1: begin if (mv == 0) begin wrap_exp++; mv = m - 1; end else mv = mv - 1; end
      2, 4: mv = 0;
      default: ;
    endcase
  endfunction

  function automatic logic [3:0] op_mask(input int op);
    case (op)
      0: return 4'b0001;  1: return 4'b0010;  2: return 4'b0100;
      3: return 4'b0011;  default: return 4'b0101;
    endcase
  endfunction

  function automatic int scan_pos();
    for (int i = 0; i < 4; i++) if (grounds[i] === 1'b0) return i;
    return 0;
  endfunction

  function automatic logic [6:0] exp_display();
    logic [15:0] v = exp_value();
    int p = scan_pos();
    return seg_of(v[4*p +: 4]);
  endfunction

  // Scan tick in cycle n (prescaler value n) at tap t: 0->1 edge of bit t.
  function automatic bit tick_at(input int n, input int rate);
    int t = (rate == 0) ? 1 : (rate == 1) ? 2 : 3;
    return (n % (1 << (t + 1))) == (1 << t);
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    {ss, clr, dec, inc} = 4'hF;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    mv = 0;
    wrap_exp = 0;
  endtask

  // {ss,clr,dec,inc} low for DEB+4 cycles, released, then settled.
  task automatic press_multi(input logic [3:0] mask);
    @(posedge clk); #1;
    {ss, clr, dec, inc} = ~mask;
    repeat (DEB + 4) @(posedge clk);
    #1;
    {ss, clr, dec, inc} = 4'hF;
    repeat (DEB + 6) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    int idx = 0;
    logic [3:0] eg;
    mode_bcd = 1'b0;
    mb = 1'b0;
    do_reset();
    #1;
    n_checks++;
    if (grounds !== 4'b1110 || display !== 7'b1111110 || value !== 16'h0 || wrap !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: got g=%b d=%b v=%h w=%b required g=1110 d=1111110 v=0000 w=0",
               grounds, display, value, wrap);
    end
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      if (tick_at(k - 1, 0)) idx = (idx + 1) % 4;
      #1;
      eg = ~(4'b0001 << idx);
      n_checks++;
      if (grounds !== eg || display !== 7'b1111110 || value !== 16'h0) begin
        n_fail++;
        $display("FAIL idle_scan cyc %0d: got g=%b d=%b v=%h required g=%b d=1111110 v=0000",
                 k, grounds, display, value, eg);
      end
    end
  endtask

  task automatic test_scan_rate();
    int press_at [3] = '{20, 80, 160};
    int idx = 0;
    int rate;
    logic [3:0] eg;
    do_reset();
    for (int k = 1; k <= 240; k++) begin
      @(posedge clk);
      rate = 0;
      for (int j = 0; j < 3; j++) if (press_at[j] + DEB + 4 <= k - 1) rate++;
      rate = rate % 3;
      if (tick_at(k - 1, rate)) idx = (idx + 1) % 4;
      #1;
      eg = ~(4'b0001 << idx);
      n_checks++;
      if (grounds !== eg) begin
        n_fail++;
        $display("FAIL scan_rate cyc %0d: grounds %b required %b", k, grounds, eg);
      end
      for (int j = 0; j < 3; j++) begin
        if (k == press_at[j]) ss = 1'b0;
        if (k == press_at[j] + 8) ss = 1'b1;
      end
    end
  endtask

  task automatic test_hex_wrap();
    int ops [4] = '{1, 1, 0, 0};
    int w0;
    mode_bcd = 1'b0;
    mb = 1'b0;
    do_reset();
    w0 = wrap_hi;
    foreach (ops[i]) begin
      press_multi(op_mask(ops[i]));
      model_op(ops[i]);
      n_checks++;
      if (value !== exp_value() || wrap_hi - w0 !== wrap_exp || display !== exp_display()) begin
        n_fail++;
        $display("FAIL hex_wrap step %0d: got v=%h wraps=%0d d=%b required v=%h wraps=%0d d=%b",
                 i, value, wrap_hi - w0, display, exp_value(), wrap_exp, exp_display());
      end
    end
  endtask

  task automatic test_bcd();
    int ops [13] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 1, 0};
    int w0;
    do_reset();
    mode_bcd = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    mb = 1'b1;
    w0 = wrap_hi;
    foreach (ops[i]) begin
      press_multi(op_mask(ops[i]));
      model_op(ops[i]);
      n_checks++;
      if (value !== exp_value() || wrap_hi - w0 !== wrap_exp || display !== exp_display()) begin
        n_fail++;
        $display("FAIL bcd step %0d: got v=%h wraps=%0d d=%b required v=%h wraps=%0d d=%b",
                 i, value, wrap_hi - w0, display, exp_value(), wrap_exp, exp_display());
      end
    end
  endtask

  task automatic test_bounce_and_combos();
    mode_bcd = 1'b0;
    mb = 1'b0;
    do_reset();
    @(posedge clk); #1;
    for (int i = 0; i < 10; i++) begin
      inc = ~inc;
      repeat (2) @(posedge clk);
      #1;
    end
    n_checks++;
    if (value !== 16'h0000) begin
      n_fail++;
      $display("FAIL bounce_quiet: value %h required 0000", value);
    end
    inc = 1'b0;
    repeat (DEB + 4) @(posedge clk);
    #1;
    inc = 1'b1;
    repeat (DEB + 6) @(posedge clk);
    #1;
    model_op(0);
    n_checks++;
    if (value !== exp_value()) begin
      n_fail++;
      $display("FAIL bounce_single: value %h required %h", value, exp_value());
    end
    press_multi(op_mask(0));
    model_op(0);
    press_multi(op_mask(3));
    model_op(3);
    n_checks++;
    if (value !== exp_value()) begin
      n_fail++;
      $display("FAIL inc_dec_same: value %h required %h", value, exp_value());
    end
    press_multi(op_mask(4));
    model_op(4);
    n_checks++;
    if (value !== 16'h0000) begin
      n_fail++;
      $display("FAIL clr_inc_same: value %h required 0000", value);
    end
  endtask

  task automatic test_random();
    int op, w0;
    mode_bcd = 1'b0;
    mb = 1'b0;
    do_reset();
    w0 = wrap_hi;
    for (int n = 0; n < 60; n++) begin
      op = int'($urandom_range(0, 9));
      if (op == 9) begin
        @(posedge clk); #1;
        mode_bcd = ~mode_bcd;
        repeat (5) @(posedge clk);
        #1;
        mb = mode_bcd;
        mv = 0;
      end else begin
        op = (op <= 3) ? 0 : (op <= 6) ? 1 : (op == 7) ? 2 : 3;
        press_multi(op_mask(op));
        model_op(op);
      end
      n_checks++;
      if (value !== exp_value() || wrap_hi - w0 !== wrap_exp || display !== exp_display()) begin
        n_fail++;
        $display("FAIL random op %0d: got v=%h wraps=%0d d=%b required v=%h wraps=%0d d=%b",
                 n, value, wrap_hi - w0, display, exp_value(), wrap_exp, exp_display());
      end
    end
  endtask

  task automatic test_mode_clear();
    int w0;
    mode_bcd = 1'b0;
    mb = 1'b0;
    do_reset();
    repeat (171) press_multi(op_mask(0));
    n_checks++;
    if (value !== 16'h00AB) begin
      n_fail++;
      $display("FAIL mode_preload: value %h required 00ab", value);
    end
    w0 = wrap_hi;
    @(posedge clk); #1;
    mode_bcd = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (value !== 16'h00AB) begin
      n_fail++;
      $display("FAIL mode_early: value %h required 00ab", value);
    end
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (value !== 16'h0000 || wrap_hi != w0) begin
      n_fail++;
      $display("FAIL mode_clear: value %h wraps %0d required 0000 wraps 0", value, wrap_hi - w0);
    end
  endtask

  task automatic test_reset_mid();
    repeat (3) press_multi(op_mask(0));
    repeat ($urandom_range(1, 7)) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (grounds !== 4'b1110 || display !== 7'b1111110 || value !== 16'h0 || wrap !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid: got g=%b d=%b v=%h w=%b required g=1110 d=1111110 v=0000 w=0",
               grounds, display, value, wrap);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_held_reset();
    mode_bcd = 1'b0;
    mb = 1'b0;
    @(posedge clk); #1;
    inc = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    n_checks++;
    if (value !== 16'h0000) begin
      n_fail++;
      $display("FAIL held_no_event: value %h required 0000", value);
    end
    inc = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    press_multi(op_mask(0));
    n_checks++;
    if (value !== 16'h0001) begin
      n_fail++;
      $display("FAIL held_repress: value %h required 0001", value);
    end
  endtask

  initial begin
    test_reset();
    test_scan_rate();
    test_hex_wrap();
    test_bcd();
    test_bounce_and_combos();
    test_random();
    test_mode_clear();
    test_reset_mid();
    test_held_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seg7_scan_counter.md
Name: seg7_scan_counter

Overview:
Parametrised multi-digit up/down counter driving a time-multiplexed common-cathode seven-segment display.
- Successor to the fixed 4-digit hex counter. Adds configurable digit count, BCD/hex mode, decrement, clear, button synchronisation and debounce, a wrap flag, and a selectable scan rate.
- All logic runs in the single `clk` domain. No derived clocks.
- Sits between board push-buttons and the display pins.

Parameters:
- NUM_DIGITS, 4, number of 4-bit digits and ground lines (2..8).
- DIV_W, 26, width of the free-running scan prescaler.
- TAP0, 15, prescaler bit used for scan rate 0 (reset rate).
- TAP1, 19, prescaler bit used for scan rate 1.
- TAP2, 25, prescaler bit used for scan rate 2. Constraint: TAP0 < TAP1 < TAP2 < DIV_W.
- DEB_CYCLES, 65536, cycles a raw button must stay stable before its new level is accepted.

Ports:
- clk, input, 1, system clock.
- rst_n, input, 1, asynchronous active-low reset.
- inc, input, 1, raw increment button, active-low press.
- dec, input, 1, raw decrement button, active-low press.
- clr, input, 1, raw clear button, active-low press.
- ss, input, 1, raw scan-rate-select button, active-low press.
- mode_bcd, input, 1, 1 = decimal digits, 0 = hex digits. Quasi-static.
- grounds, output, NUM_DIGITS, active-low digit enables, exactly one low.
- display, output, 7, segments a..g as bits 6..0, active-high.
- value, output, 4*NUM_DIGITS, packed counter; digit 0 in bits [3:0].
- wrap, output, 1, one-cycle pulse on overflow or underflow.

Behaviour:
- **Reset (rst_n low, async):**
  - all digits = 0; value = 0
  - scan index = 0; grounds = all ones except bit 0 low
  - display = 7'b1111110
  - wrap = 0; rate_sel = 0
  - sync/debounce stages = 1 (released); prescaler = 0
- **Button conditioning** (inc, dec, clr, ss each):
  - 2-flop synchroniser, then a debounce counter.
  - The debounced level changes only after the synchronised input differs from it for DEB_CYCLES consecutive cycles. Any bounce restarts the count.
  - A 1→0 transition of the debounced level yields a one-cycle press event.
  - Latency from raw press to event: 2 + DEB_CYCLES + 1 cycles.
- **Counter update** (registered, priority order, one cycle after the event):
  1. clr event: all digits → 0. Concurrent inc/dec are ignored. No wrap.
  2. inc and dec events in the same cycle: no change.
  3. inc event: add 1 with ripple carry. A digit at its max (F hex, 9 BCD) → 0 and carries.
  4. dec event: subtract 1 with borrow. A digit at 0 → max and borrows.
- **Wrap:**
  - All digits at max + inc → all 0, wrap = 1 for one cycle.
  - All 0 + dec → all max, wrap = 1.
- **mode_bcd change:** any change (sampled through a 2-flop synchroniser, edge-detected) clears all digits to 0 on the following cycle. This prevents illegal BCD digits. No wrap.
- **Scan prescaler:**
  - DIV_W-bit counter increments every clk and wraps naturally.
  - Scan tick = 0→1 transition of prescaler[TAP(rate_sel)], detected with a registered copy of that bit.
  - On tick: scan index ← (index + 1) mod NUM_DIGITS; grounds ← all ones with bit[index] low.
  - Digit index i drives ground bit i.
- **Rate select:** ss event advances rate_sel 0→1→2→0. A tick must not occur solely because the tap switched. The tap-history register is reloaded with the new tap's current value on the switch cycle.
- **Segment decode** (combinational from the digit at the scan index):
  - 0:1111110, 1:0110000, 2:1101101, 3:1111001
  - 4:0110011, 5:1011011, 6:1011111, 7:1110000
  - 8:1111111, 9:1111011, A:1110111, b:0011111
  - C:1001110, d:0111101, E:1001111, F:1000111
- **Registered timing:** grounds and the index are registered. display is combinational from registered state, so it updates in the same cycle as grounds.
- **Reset mid-operation:** asynchronous assertion immediately forces the reset values. A held button after reset release produces no event until released and pressed again.

Test Plan:
- Bench parameters: NUM_DIGITS=4, DIV_W=8, TAP0=1, TAP1=2, TAP2=3, DEB_CYCLES=4.
- Reset then idle 40 clk → grounds cycles 1110,1101,1011,0111 changing every 4 clk; display = 1111110 throughout; value = 0.
- Hex mode, value = 16'hFFFE, two clean inc presses → value FFFF then 0000; wrap high exactly one cycle on the second; display shows F then 0.
- BCD mode, value = 0009, inc → 0010; from 0000, dec → 9999 with one wrap pulse.
- inc bouncing (toggle every 2 clk for 20 clk, then held low) → exactly one increment. Simultaneous inc+dec events → value unchanged. clr+inc in the same cycle → 0000.
- ss pressed once → scan period changes from 4 to 8 clk with no extra tick at the switch; three presses total → back to 4 clk.
- Toggle mode_bcd with value = 00AB → value 0000 two to three cycles later. Assert rst_n mid-count → all outputs at reset values immediately.
